axilite_reg_bridge: RTL and testbench

//  AXI4-Lite slave to local register-bus bridge with write and read paths. AW and W are accepted independently; reads use a variable-latency handshake and a timeout.
//  Out-of-window addresses answer DECERR; unanswered reads answer SLVERR. Sits between the interconnect and peripheral register files (UART, timer, GPIO).

---
 rtl/axilite_pkg.sv | 28 ++
 rtl/axilite_addr_decode.sv | 32 +++
 rtl/axilite_reg_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_axilite_reg_bridge.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axilite_pkg.sv
// +------------------------------------------------------------------+
// | axilite_pkg: response codes and FSM encodings for the bridge     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_ISSUE   = 2'd1,
    W_RESP    = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2,
    R_RESP  = 2'd3
  } r_state_e;

endpackage

`default_nettype wire

// File: rtl/axilite_addr_decode.sv
// +------------------------------------------------------------------+
// | axilite_addr_decode: window hit test and aligned local offset    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module axilite_addr_decode #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W:0]   ADDR_SPAN = 'h1000
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [ADDR_W-1:0] offset
);

  localparam int                STRB_W       = DATA_W / 8;
  localparam logic [ADDR_W:0]   c_lo         = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]   c_hi         = c_lo + ADDR_SPAN - (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(STRB_W - 1);

  // One extra bit keeps BASE_ADDR+ADDR_SPAN-1 from wrapping at the top of the map.
  logic [ADDR_W:0] w_addr_ext;
  assign w_addr_ext = {1'b0, addr};

  assign hit    = (w_addr_ext >= c_lo) && (w_addr_ext <= c_hi);
  assign offset = (addr - BASE_ADDR) & c_align_mask;

endmodule

`default_nettype wire

// File: rtl/axilite_reg_bridge.sv
// +------------------------------------------------------------------+
// | axilite_reg_bridge: AXI4-Lite slave to local register bus        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module axilite_reg_bridge
  import axilite_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W:0]   ADDR_SPAN = 'h1000,
  parameter int                RD_TMO    = 255
) (
  input  logic                  axi_clk,
  input  logic                  axi_resetn,
  input  logic [ADDR_W-1:0]     axi_awaddr,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [DATA_W-1:0]     axi_wdata,
  input  logic [DATA_W/8-1:0]   axi_wstrb,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  input  logic [ADDR_W-1:0]     axi_araddr,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic [DATA_W-1:0]     axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_strb,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_valid,
  input  logic [DATA_W-1:0]     rd_data
);

  localparam int STRB_W = DATA_W / 8;

  w_state_e r_w_state, w_w_next;
  r_state_e r_r_state, w_r_next;

  logic              r_awready, r_wready, r_arready, r_bvalid, r_rvalid;
  logic [1:0]        r_bresp, r_rresp;
  logic [DATA_W-1:0] r_rdata;
  logic              r_wr_en, r_rd_en, r_aw_hit, r_ar_hit;
  logic [ADDR_W-1:0] r_aw_addr, r_wr_addr, r_rd_addr;
  logic [DATA_W-1:0] r_w_data, r_wr_data;
  logic [STRB_W-1:0] r_w_strb, r_wr_strb;
  logic [7:0]        r_tmo_cnt;

  logic              w_aw_hs, w_w_hs, w_ar_hs, w_aw_have, w_w_have, w_tmo;
  logic              w_aw_hit, w_ar_hit;
  logic [ADDR_W-1:0] w_aw_addr_cur, w_aw_offset, w_ar_offset;
  logic [DATA_W-1:0] w_wdata_cur;
  logic [STRB_W-1:0] w_wstrb_cur;

  assign w_aw_hs   = axi_awvalid & r_awready;
  assign w_w_hs    = axi_wvalid & r_wready;
  assign w_ar_hs   = axi_arvalid & r_arready;
  assign w_aw_have = w_aw_hs | ~r_awready;
  assign w_w_have  = w_w_hs | ~r_wready;
  assign w_tmo     = (r_tmo_cnt == 8'(RD_TMO - 1));

  // A channel still open means its payload is arriving this cycle, otherwise use the hold.
  assign w_aw_addr_cur = r_awready ? axi_awaddr : r_aw_addr;
  assign w_wdata_cur   = r_wready ? axi_wdata : r_w_data;
  assign w_wstrb_cur   = r_wready ? axi_wstrb : r_w_strb;

  axilite_addr_decode #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR), .ADDR_SPAN(ADDR_SPAN)
  ) u_aw_decode (
    .addr(w_aw_addr_cur), .hit(w_aw_hit), .offset(w_aw_offset)
  );

  axilite_addr_decode #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR), .ADDR_SPAN(ADDR_SPAN)
  ) u_ar_decode (
    .addr(axi_araddr), .hit(w_ar_hit), .offset(w_ar_offset)
  );

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_w_state <= W_COLLECT;
      r_r_state <= R_IDLE;
    end else begin
      r_w_state <= w_w_next;
      r_r_state <= w_r_next;
    end
  end

  always_comb begin
    w_w_next = r_w_state;
    case (r_w_state)
      W_COLLECT: if (w_aw_have && w_w_have) w_w_next = W_ISSUE;
      W_ISSUE:   w_w_next = W_RESP;
      W_RESP:    if (axi_bready) w_w_next = W_COLLECT;
      default:   w_w_next = W_COLLECT;
    endcase
  end

  always_comb begin
    w_r_next = r_r_state;
    case (r_r_state)
      R_IDLE:  if (w_ar_hs) w_r_next = R_ISSUE;
      R_ISSUE: w_r_next = r_ar_hit ? R_WAIT : R_RESP;
      R_WAIT:  if (rd_valid || w_tmo) w_r_next = R_RESP;
      R_RESP:  if (axi_rready) w_r_next = R_IDLE;
      default: w_r_next = R_IDLE;
    endcase
  end

  // Write datapath: the local strobe is registered on the edge that enters W_ISSUE.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_aw_hit  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_aw_hs) begin
        r_aw_addr <= axi_awaddr;
        r_awready <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_data <= axi_wdata;
        r_w_strb <= axi_wstrb;
        r_wready <= 1'b0;
      end
      case (r_w_state)
        W_COLLECT: if (w_w_next == W_ISSUE) begin
          r_aw_hit <= w_aw_hit;
          r_wr_en  <= w_aw_hit;
          if (w_aw_hit) begin
            r_wr_addr <= w_aw_offset;
            r_wr_data <= w_wdata_cur;
            r_wr_strb <= w_wstrb_cur;
          end
        end
        W_ISSUE: begin
          r_bvalid <= 1'b1;
          r_bresp  <= r_aw_hit ? RESP_OKAY : RESP_DECERR;
        end
        W_RESP: if (axi_bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read datapath: R_WAIT lasts at most RD_TMO cycles; data on the last one still wins.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_ar_hit  <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_r_state)
        R_IDLE: if (w_ar_hs) begin
          r_arready <= 1'b0;
          r_ar_hit  <= w_ar_hit;
          r_rd_en   <= w_ar_hit;
          if (w_ar_hit) r_rd_addr <= w_ar_offset;
        end
        R_ISSUE: begin
          r_tmo_cnt <= '0;
          if (!r_ar_hit) begin
            r_rdata  <= '0;
            r_rresp  <= RESP_DECERR;
            r_rvalid <= 1'b1;
          end
        end
        R_WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + 8'd1;
          if (rd_valid) begin
            r_rdata  <= rd_data;
            r_rresp  <= RESP_OKAY;
            r_rvalid <= 1'b1;
          end else if (w_tmo) begin
            r_rdata  <= '0;
            r_rresp  <= RESP_SLVERR;
            r_rvalid <= 1'b1;
          end
        end
        R_RESP: if (axi_rready) begin
          r_rvalid  <= 1'b0;
          r_arready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign axi_awready = r_awready;
  assign axi_wready  = r_wready;
  assign axi_bvalid  = r_bvalid;
  assign axi_bresp   = r_bresp;
  assign axi_arready = r_arready;
  assign axi_rvalid  = r_rvalid;
  assign axi_rresp   = r_rresp;
  assign axi_rdata   = r_rdata;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_strb     = r_wr_strb;
  assign rd_en       = r_rd_en;
  assign rd_addr     = r_rd_addr;

endmodule

`default_nettype wire

// File: tb/tb_axilite_reg_bridge.sv
// +------------------------------------------------------------------+
// | tb_axilite_reg_bridge: directed self-checking bench for bridge   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_axilite_reg_bridge;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam logic [32:0] SPAN   = 33'h0_0000_1000;
  localparam int          RD_TMO = 16;

  logic        axi_clk, axi_resetn;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [3:0]  axi_wstrb;
  logic [1:0]  axi_bresp, axi_rresp;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        wr_en, rd_en, rd_valid;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [3:0]  wr_strb;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  axilite_reg_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .ADDR_SPAN(SPAN), .RD_TMO(RD_TMO)
  ) dut (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  // Pulse counters; sampled on posedge so they see the value held during the previous cycle.
  always @(posedge axi_clk) begin
    if (wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= wr_addr;
      last_wr_data <= wr_data;
    end
    if (rd_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge axi_clk);
  endtask

  task automatic concurrent_rw();
    bit aw_p, w_p, ar_p, b_done, r_done;
    int rd_cd;
    int wr0;
    aw_p = 0; w_p = 0; ar_p = 0; b_done = 0; r_done = 0; rd_cd = 0;
    wr0 = wr_cnt;
    for (int cyc = 0; cyc < 80 && !(b_done && r_done); cyc++) begin
      tick();
      if (aw_p) begin axi_awvalid = 1'b0; aw_p = 0; end
      if (w_p)  begin axi_wvalid  = 1'b0; w_p  = 0; end
      if (ar_p) begin axi_arvalid = 1'b0; ar_p = 0; end
      rd_valid = 1'b0;
      if (rd_en) rd_cd = 3;
      else if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin rd_valid = 1'b1; rd_data = 32'h0BAD_F00D; end
      end
      if (cyc == 1) begin axi_arvalid = 1'b1; axi_araddr = BASE + 32'h30; end
      if (cyc == 2) begin axi_awvalid = 1'b1; axi_awaddr = BASE + 32'h20; end
      if (cyc == 5) begin axi_wvalid = 1'b1; axi_wdata = 32'hA5A5_0F0F; axi_wstrb = 4'hF; end
      axi_bready = 1'($urandom_range(0, 1));
      axi_rready = 1'($urandom_range(0, 1));
      aw_p = axi_awvalid & axi_awready;
      w_p  = axi_wvalid & axi_wready;
      ar_p = axi_arvalid & axi_arready;
      if (axi_bvalid && axi_bready && !b_done) begin
        b_done = 1;
        check("conc_bresp", axi_bresp, 2'b00);
      end
      if (axi_rvalid && axi_rready && !r_done) begin
        r_done = 1;
        check("conc_rdata", axi_rdata, 32'h0BAD_F00D);
        check("conc_rresp", axi_rresp, 2'b00);
      end
    end
    check("conc_b_done", b_done, 1'b1);
    check("conc_r_done", r_done, 1'b1);
    tick();
    axi_bready = 1'b1;
    axi_rready = 1'b1;
    rd_valid   = 1'b0;
    tick();
    tick();
    check("conc_wr_cnt", wr_cnt - wr0, 1);
    check("conc_wr_addr", last_wr_addr, 32'h20);
    check("conc_wr_data", last_wr_data, 32'hA5A5_0F0F);
  endtask

  initial begin
    int wr0, rd0;
    axi_resetn = 1'b0;
    axi_awaddr = '0; axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0;
    axi_bready = 1'b1; axi_araddr = '0; axi_arvalid = 1'b0; axi_rready = 1'b1;
    rd_valid = 1'b0; rd_data = '0;
    tick();
    tick();
    check("rst_awready", axi_awready, 1'b1);
    check("rst_wready", axi_wready, 1'b1);
    check("rst_arready", axi_arready, 1'b1);
    check("rst_valids", {axi_bvalid, axi_rvalid, wr_en, rd_en}, 4'b0000);
    check("rst_rdata", axi_rdata, 32'h0);
    axi_resetn = 1'b1;
    tick();

    // 1: same-cycle AW+W
    axi_awaddr = BASE + 32'h8; axi_awvalid = 1'b1;
    axi_wdata = 32'hDEAD_BEEF; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    check("t1_wr_en", wr_en, 1'b1);
    check("t1_wr_addr", wr_addr, 32'h8);
    check("t1_wr_data", wr_data, 32'hDEAD_BEEF);
    check("t1_wr_strb", wr_strb, 4'hF);
    check("t1_bvalid_early", axi_bvalid, 1'b0);
    check("t1_awready_busy", axi_awready, 1'b0);
    tick();
    check("t1_wr_en_off", wr_en, 1'b0);
    check("t1_bvalid", axi_bvalid, 1'b1);
    check("t1_bresp", axi_bresp, 2'b00);
    tick();
    check("t1_bvalid_clr", axi_bvalid, 1'b0);
    check("t1_awready_back", axi_awready, 1'b1);
    check("t1_wready_back", axi_wready, 1'b1);

    // 2: W arrives three cycles before AW
    wr0 = wr_cnt;
    axi_wdata = 32'h0000_CAFE; axi_wstrb = 4'h3; axi_wvalid = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    check("t2_wready_drop", axi_wready, 1'b0);
    check("t2_awready_open", axi_awready, 1'b1);
    check("t2_no_wr_early", wr_en, 1'b0);
    tick();
    tick();
    axi_awaddr = BASE + 32'h10; axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    check("t2_wr_en", wr_en, 1'b1);
    check("t2_wr_addr", wr_addr, 32'h10);
    check("t2_wr_data", wr_data, 32'h0000_CAFE);
    check("t2_wr_strb", wr_strb, 4'h3);
    tick();
    check("t2_bvalid", axi_bvalid, 1'b1);
    check("t2_bresp", axi_bresp, 2'b00);
    tick();
    tick();
    check("t2_one_write", wr_cnt - wr0, 1);

    // 4: in-window read, data five cycles after rd_en, rready stalled
    axi_rready = 1'b0;
    axi_araddr = BASE + 32'h4; axi_arvalid = 1'b1;
    tick();
    axi_arvalid = 1'b0;
    check("t4_rd_en", rd_en, 1'b1);
    check("t4_rd_addr", rd_addr, 32'h4);
    check("t4_arready_busy", axi_arready, 1'b0);
    repeat (4) tick();
    check("t4_rvalid_early", axi_rvalid, 1'b0);
    rd_valid = 1'b1; rd_data = 32'h0000_1234;
    tick();
    rd_valid = 1'b1; rd_data = 32'h5555_5555;
    check("t4_rvalid", axi_rvalid, 1'b1);
    check("t4_rdata", axi_rdata, 32'h0000_1234);
    check("t4_rresp", axi_rresp, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_stall_rvalid", axi_rvalid, 1'b1);
      check("t4_stall_rdata", axi_rdata, 32'h0000_1234);
      check("t4_stall_arready", axi_arready, 1'b0);
    end
    rd_valid = 1'b0;
    axi_rready = 1'b1;
    tick();
    check("t4_rvalid_clr", axi_rvalid, 1'b0);
    check("t4_arready_back", axi_arready, 1'b1);

    // 3: out-of-window write and read
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    axi_awaddr = BASE + SPAN[31:0]; axi_awvalid = 1'b1;
    axi_wdata = 32'h1111_2222; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
    axi_araddr = BASE - 32'h4; axi_arvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    check("t3_no_wr_en", wr_en, 1'b0);
    check("t3_no_rd_en", rd_en, 1'b0);
    tick();
    check("t3_bvalid", axi_bvalid, 1'b1);
    check("t3_bresp", axi_bresp, 2'b11);
    check("t3_rvalid", axi_rvalid, 1'b1);
    check("t3_rresp", axi_rresp, 2'b11);
    check("t3_rdata", axi_rdata, 32'h0);
    tick();
    tick();
    check("t3_wr_cnt", wr_cnt - wr0, 0);
    check("t3_rd_cnt", rd_cnt - rd0, 0);

    // 5a: timeout after RD_TMO cycles in R_WAIT
    axi_araddr = BASE + 32'hC; axi_arvalid = 1'b1;
    tick();
    axi_arvalid = 1'b0;
    for (int i = 1; i <= RD_TMO; i++) tick();
    check("t5_rvalid_before_tmo", axi_rvalid, 1'b0);
    tick();
    check("t5_tmo_rvalid", axi_rvalid, 1'b1);
    check("t5_tmo_rresp", axi_rresp, 2'b10);
    check("t5_tmo_rdata", axi_rdata, 32'h0);
    tick();
    tick();

    // 5b: data on the expiry cycle wins
    axi_araddr = BASE + 32'hC; axi_arvalid = 1'b1;
    tick();
    axi_arvalid = 1'b0;
    for (int i = 1; i <= RD_TMO; i++) tick();
    rd_valid = 1'b1; rd_data = 32'h7777_8888;
    tick();
    rd_valid = 1'b0;
    check("t5_edge_rvalid", axi_rvalid, 1'b1);
    check("t5_edge_rresp", axi_rresp, 2'b00);
    check("t5_edge_rdata", axi_rdata, 32'h7777_8888);
    tick();
    tick();

    // 6: concurrent traffic with random stalls, then reset mid R_WAIT
    concurrent_rw();
    axi_araddr = BASE + 32'h40; axi_arvalid = 1'b1;
    axi_awaddr = BASE + 32'h44; axi_awvalid = 1'b1;
    tick();
    axi_arvalid = 1'b0; axi_awvalid = 1'b0;
    repeat (4) tick();
    axi_resetn = 1'b0;
    #1;
    check("t6_rst_awready", axi_awready, 1'b1);
    check("t6_rst_arready", axi_arready, 1'b1);
    check("t6_rst_wready", axi_wready, 1'b1);
    check("t6_rst_valids", {axi_bvalid, axi_rvalid, wr_en, rd_en}, 4'b0000);
    check("t6_rst_resps", {axi_bresp, axi_rresp}, 4'b0000);
    check("t6_rst_rdata", axi_rdata, 32'h0);
    check("t6_rst_wr_addr", wr_addr, 32'h0);
    check("t6_rst_wr_data", wr_data, 32'h0);
    check("t6_rst_wr_strb", wr_strb, 4'h0);
    check("t6_rst_rd_addr", rd_addr, 32'h0);
    tick();
    axi_resetn = 1'b1;
    tick();
    tick();
    check("t6_post_rvalid", axi_rvalid, 1'b0);
    check("t6_post_bvalid", axi_bvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
